data_mem_sized: RTL
===================

Name: data_mem_sized

Overview:
- Parametrised data memory for the MIPS pipeline MEM stage; next generation after the fixed 64x32 word-only memory.
- Supports byte/half/word loads and stores with sign/zero extension and misalignment detection.
- Uses a valid/ack request handshake with configurable access latency, so the pipeline stalls on `busy` when modelling slow memory.

Parameters:
- DEPTH, 64, number of 32-bit words; power of two, >= 2.
- LATENCY, 1, cycles from request acceptance to ack; range 1..15.
- ADDR_W, $clog2(DEPTH)+2, byte address width (derived; not overridden).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  load zero-extends when 1 (lbu/lhu); ignored for word and stores.
- addr  in  ADDR_W  byte address, little-endian lanes.
- wd  in  32  store data; byte in [7:0], half in [15:0].
- rd  out  32  load result, extended; valid only while ack=1.
- ack  out  1  one-cycle completion pulse for loads and stores.
- err  out  1  misaligned/illegal flag, qualified by ack.
- busy  out  1  request in flight; new requests ignored.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: rd=0, ack=0, err=0, busy=0, state=IDLE, counter=0. Memory array is not cleared; contents are undefined until written.
- States:
  - IDLE: busy=0.
  - WAIT: busy=1.
  - busy is a decode of state.
- Acceptance: at an edge E0 with state=IDLE and req_valid=1.
  - Latch addr, wd, size, write, unsigned.
  - Load counter with LATENCY-1; go to WAIT.
- WAIT, counter != 0: decrement.
- WAIT, counter == 0: perform the access, register rd/err, assert ack, return to IDLE.
  - ack therefore rises at edge E0+LATENCY and lasts exactly one cycle.
  - With LATENCY=1, ack is high the cycle after acceptance.
- Back-to-back: the ack cycle has state=IDLE, so a req_valid in that cycle is accepted at the next edge. Throughput is one request per LATENCY+1 cycles.
- req_valid while busy=1 is ignored; the requester must hold the request.
- Misaligned/illegal: half with addr[0]=1, word with addr[1:0]!=0, or size=11.
  - Completes with the same latency, ack=1, err=1, rd=0.
  - No memory write occurs.
- Word index = addr[ADDR_W-1:2]; lane = addr[1:0].
- Store byte: writes only lane addr[1:0] with wd[7:0]. Store half: writes lanes {addr[1],0} and {addr[1],1} with wd[15:0]. Store word: writes all lanes.
- Unwritten lanes are preserved: per-lane write enables, no read-modify-write hazards.
- Loads: extract the selected lane(s).
  - Signed: sign-extend from bit 7/15.
  - Unsigned: zero-extend.
  - Word: passthrough.
- Store ack: rd=0, err=0.
- Load immediately after a store to the same word sees the new data, since the store completes before the next acceptance.
- Reset mid-operation: state returns to IDLE, no ack pulse, and any pending store is discarded (array unchanged).
- Address wrap: none is possible; ADDR_W exactly spans DEPTH words.

Decomposition:
- Shared include data_mem_defs.vh holds:
  - size codes SIZE_B=2'b00, SIZE_H=2'b01, SIZE_W=2'b10;
  - state encodings IDLE/WAIT.
- One combinational sub-module, load_align:
  - inputs: 32-bit word, lane, size, unsigned;
  - output: extended 32-bit result.
- load_align is reused later by the cache fill path.
- Misalignment check stays inline.

Test Plan:
- Fill and readback: LATENCY=1, store 64 random words at addresses 0,4,...,252, then load each. Every rd must match, each ack arrives exactly 1 cycle after acceptance, and err=0 throughout.
- Sub-word stores:
  - store word 0x11223344 to addr 8, then sb 0xAA to addr 9, then sh 0xBEEF to addr 10;
  - lw addr 8 -> 0xBEEFAA44.
- Extension: with 0xBEEFAA44 at addr 8:
  - lb 9 -> 0xFFFFFFAA;
  - lbu 9 -> 0x000000AA;
  - lh 10 -> 0xFFFFBEEF;
  - lhu 10 -> 0x0000BEEF;
  - lb 8 -> 0x00000044.
- Misalignment:
  - lw addr 6 and sh addr 5 -> ack with err=1, rd=0;
  - follow-up lw addr 4 shows the word unchanged;
  - size=11 -> err=1.
- Latency/handshake: LATENCY=4.
  - busy is high exactly 4 cycles per request and ack follows acceptance by 4 edges.
  - A req_valid change while busy is ignored.
  - A request presented during the ack cycle is accepted at the next edge.
- Reset mid-operation: LATENCY=4, store 0xDEADBEEF to addr 0 (previously 0x0), assert rst for 1 cycle at count 2.
  - No ack; busy=0 after reset.
  - lw addr 0 -> 0x00000000.

Source files
------------

// File: rtl/data_mem_sized_pkg.sv
// Shared definitions for the sized data memory: access-size codes and FSM states.
// No logic; constants and types only.
// Imported by data_mem_sized and load_align.
package data_mem_sized_pkg;

    // Access size codes carried on req_size
    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    // Request FSM: IDLE accepts, WAIT counts down the modelled access latency
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/data_mem_sized_load_align.sv
// Load lane extraction: picks byte/half/word from a memory word and sign/zero-extends it.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
module load_align
    import data_mem_sized_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] result
);

    logic [7:0]  b_sel;
    logic [15:0] h_sel;

    // Select the addressed lane(s) and extend to 32 bits
    always_comb begin
        b_sel  = word[{lane, 3'b000} +: 8];
        h_sel  = lane[1] ? word[31:16] : word[15:0];
        result = '0;
        case (size)
            SIZE_B:  result = is_unsigned ? {24'h0, b_sel} : {{24{b_sel[7]}}, b_sel};
            SIZE_H:  result = is_unsigned ? {16'h0, h_sel} : {{16{h_sel[15]}}, h_sel};
            SIZE_W:  result = word;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/data_mem_sized.sv
// Byte/half/word data memory with valid/ack handshake and parametrised access latency.
// Latency: ack rises LATENCY edges after acceptance and lasts one cycle.
// Backpressure: busy=1 while a request is in flight; req_valid is ignored until IDLE.
module data_mem_sized
    import data_mem_sized_pkg::*;
#(
    parameter  int DEPTH   = 64,
    parameter  int LATENCY = 1,
    localparam int ADDR_W  = $clog2(DEPTH) + 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wd,
    output logic [31:0]       rd,
    output logic              ack,
    output logic              err,
    output logic              busy
);

    localparam int         IDX_W    = ADDR_W - 2;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              accept;
    logic              fire;

    logic              write_q;
    logic [1:0]        size_q;
    logic              unsigned_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wd_q;

    logic [31:0]       mem [DEPTH];
    logic [IDX_W-1:0]  idx;
    logic [1:0]        lane;
    logic              bad;
    logic [3:0]        lane_we;
    logic [31:0]       lane_dat;
    logic              mem_we;
    logic [31:0]       mem_word;
    logic [31:0]       load_val;

    assign idx      = addr_q[ADDR_W-1:2];
    assign lane     = addr_q[1:0];
    assign mem_word = mem[idx];
    assign busy     = (state_q == WAIT);
    // A reset in the completing cycle discards the pending store
    assign mem_we   = fire && write_q && !bad && !rst;

    // State and latency counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: accept in IDLE, count down in WAIT, complete when the count is spent
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        fire    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    accept  = 1'b1;
                    cnt_d   = CNT_INIT;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    fire    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Capture the request at acceptance so the requester may change inputs while busy
    always_ff @(posedge clk) begin
        if (rst) begin
            write_q    <= 1'b0;
            size_q     <= SIZE_W;
            unsigned_q <= 1'b0;
            addr_q     <= '0;
            wd_q       <= '0;
        end else if (accept) begin
            write_q    <= req_write;
            size_q     <= req_size;
            unsigned_q <= req_unsigned;
            addr_q     <= addr;
            wd_q       <= wd;
        end
    end

    // Alignment check: half needs an even address, word needs a 4-byte boundary, size 11 is illegal
    always_comb begin
        bad = 1'b0;
        case (size_q)
            SIZE_B:  bad = 1'b0;
            SIZE_H:  bad = lane[0];
            SIZE_W:  bad = (lane != 2'b00);
            default: bad = 1'b1;
        endcase
    end

    // Per-lane write enables with store data replicated onto every lane it could land in
    always_comb begin
        lane_we  = 4'b0000;
        lane_dat = wd_q;
        case (size_q)
            SIZE_B: begin
                lane_we  = 4'b0001 << lane;
                lane_dat = {4{wd_q[7:0]}};
            end
            SIZE_H: begin
                lane_we  = lane[1] ? 4'b1100 : 4'b0011;
                lane_dat = {2{wd_q[15:0]}};
            end
            SIZE_W:  lane_we = 4'b1111;
            default: lane_we = 4'b0000;
        endcase
    end

    // Memory array: only enabled lanes are written, the rest keep their contents
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_we[i]) begin
                    mem[idx][8*i +: 8] <= lane_dat[8*i +: 8];
                end
            end
        end
    end

    load_align u_load_align (
        .word        (mem_word),
        .lane        (lane),
        .size        (size_q),
        .is_unsigned (unsigned_q),
        .result      (load_val)
    );

    // Completion outputs: one-cycle ack, rd only carries data for good loads
    always_ff @(posedge clk) begin
        if (rst) begin
            rd  <= '0;
            ack <= 1'b0;
            err <= 1'b0;
        end else begin
            ack <= fire;
            err <= fire && bad;
            rd  <= (fire && !bad && !write_q) ? load_val : '0;
        end
    end

endmodule
